// File: rtl/wb_gpio_panel_pkg.sv
// ---------------------------------------------------------------------------
// wb_gpio_panel_pkg
// Shared definitions for the Wishbone board-panel GPIO block: register word
// offsets, interrupt bit positions, reset values of the software-visible
// registers and the active-low hex-to-seven-segment glyph table.
// No ports (package).
// ---------------------------------------------------------------------------
package wb_gpio_panel_pkg;

    // Register word offsets (wb_adr_i[4:2])
    localparam logic [2:0] OFF_LED      = 3'd0;
    localparam logic [2:0] OFF_RG       = 3'd1;
    localparam logic [2:0] OFF_SEG      = 3'd2;
    localparam logic [2:0] OFF_SW       = 3'd3;
    localparam logic [2:0] OFF_KEY      = 3'd4;
    localparam logic [2:0] OFF_INT_EN   = 3'd5;
    localparam logic [2:0] OFF_INT_STAT = 3'd6;
    localparam logic [2:0] OFF_RSVD     = 3'd7;

    // Interrupt source bit positions in INT_EN / INT_STAT
    localparam int INT_SW   = 0;
    localparam int INT_STEP = 1;

    // Register reset values
    localparam logic [15:0] LED_RST      = 16'h0000;
    localparam logic [3:0]  RG_RST       = 4'h0;
    localparam logic [31:0] SEG_RST      = 32'h0000_0000;
    localparam logic [1:0]  INT_EN_RST   = 2'b00;
    localparam logic [1:0]  INT_STAT_RST = 2'b00;

    // Glyphs packed 7 bits per nibble value, entry 0 in the low bits.
    // Bit order inside a glyph is [6]=a .. [0]=g, 0 = segment lit.
    localparam logic [16*7-1:0] SEG_TABLE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        return SEG_TABLE[{3'b000, nib} * 7 +: 7];
    endfunction

endpackage

// File: rtl/wb_gpio_panel_seg_scan.sv
// ---------------------------------------------------------------------------
// wb_gpio_panel_seg_scan
// Multiplexes an 8-digit seven-segment display. Each digit stays selected for
// SCAN_DIV clocks; outputs only change at a digit boundary so a register
// update never glitches the digit currently lit.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   seg_i      32-bit display value, nibble n drives digit n
//   num_csn_o  digit select, active-low one-hot
//   num_a_g_o  segments [6]=a .. [0]=g, active-low
// ---------------------------------------------------------------------------
module wb_gpio_panel_seg_scan
    import wb_gpio_panel_pkg::*;
#(
    parameter int SCAN_DIV = 5000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] seg_i,
    output logic [7:0]  num_csn_o,
    output logic [6:0]  num_a_g_o
);

    localparam int                CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       csn_q, csn_d;
    logic [6:0]       seg_q, seg_d;
    logic             wrap;

    always_comb begin
        wrap  = (cnt_q == CNT_MAX);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        // 3-bit index wraps 7 -> 0 on its own
        idx_d = wrap ? idx_q + 3'd1 : idx_q;
        csn_d = csn_q;
        seg_d = seg_q;
        if (wrap) begin
            csn_d = ~(8'd1 << idx_d);
            seg_d = seg_decode(seg_i[{idx_d, 2'b00} +: 4]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            idx_q <= 3'd0;
            csn_q <= 8'hFE;
            seg_q <= seg_decode(4'h0);
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            csn_q <= csn_d;
            seg_q <= seg_d;
        end
    end

    assign num_csn_o = csn_q;
    assign num_a_g_o = seg_q;

endmodule

// File: rtl/wb_gpio_panel.sv
// ---------------------------------------------------------------------------
// wb_gpio_panel
// Wishbone classic slave exposing the board panel: 16 LEDs, two bicolour LEDs,
// an 8-digit multiplexed seven-segment display, 8 switches, a 4x4 key matrix
// and two step buttons, plus a level interrupt on switch change / step press.
// Ports:
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i, wb_we_i   Wishbone cycle / strobe / write enable
//   wb_adr_i, wb_sel_i, wb_dat_i  byte address ([4:2] decoded), lanes, data
//   wb_dat_o, wb_ack_o            registered read data and acknowledge
//   led, led_rg0, led_rg1         LED drives, 1 = on
//   num_csn, num_a_g              seven-segment digit select / segments
//   switch, btn_key_col,
//   btn_key_row, btn_step         raw panel inputs (synchronised internally)
//   gpio_int                      level interrupt, active-high
// ---------------------------------------------------------------------------
module wb_gpio_panel
    import wb_gpio_panel_pkg::*;
#(
    parameter int SCAN_DIV    = 5000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [15:0] led,
    output logic [1:0]  led_rg0,
    output logic [1:0]  led_rg1,
    output logic [7:0]  num_csn,
    output logic [6:0]  num_a_g,
    input  logic [7:0]  switch,
    input  logic [3:0]  btn_key_col,
    input  logic [3:0]  btn_key_row,
    input  logic [1:0]  btn_step,
    output logic        gpio_int
);

    localparam int IN_W = 18;  // {btn_step, row, col, switch}

    logic [SYNC_STAGES-1:0][IN_W-1:0] sync_q;
    logic [SYNC_STAGES-1:0]           sync_vld_q;
    logic [IN_W-1:0]                  synced;
    logic [7:0]                       sw_s;
    logic [3:0]                       col_s, row_s;
    logic [1:0]                       step_s;

    logic [7:0]  sw_hist_q;
    logic [1:0]  step_hist_q;
    logic        hist_vld_q;

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [15:0] led_q, led_d;
    logic [3:0]  rg_q, rg_d;
    logic [31:0] seg_q, seg_d;
    logic [1:0]  int_en_q, int_en_d;
    logic [1:0]  int_stat_q, int_stat_d;
    logic        irq_q, irq_d;

    logic        req, wr_commit, rd_cap;
    logic [2:0]  off;
    logic [1:0]  int_set, int_clr;
    logic [31:0] rdata;
    logic        unused_adr;

    assign synced = sync_q[SYNC_STAGES-1];
    assign sw_s   = synced[7:0];
    assign col_s  = synced[11:8];
    assign row_s  = synced[15:12];
    assign step_s = synced[17:16];

    assign off        = wb_adr_i[4:2];
    assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

    // Request is sampled in the cycle before ack; the write lands in the ack
    // cycle while the master is still holding the request.
    assign req       = wb_cyc_i & wb_stb_i;
    assign wr_commit = ack_q & req & wb_we_i;
    assign rd_cap    = req & ~ack_q & ~wb_we_i;

    always_comb begin
        ack_d = req & ~ack_q;

        led_d    = led_q;
        rg_d     = rg_q;
        seg_d    = seg_q;
        int_en_d = int_en_q;
        int_clr  = 2'b00;
        if (wr_commit) begin
            case (off)
                OFF_LED: begin
                    if (wb_sel_i[0]) led_d[7:0]  = wb_dat_i[7:0];
                    if (wb_sel_i[1]) led_d[15:8] = wb_dat_i[15:8];
                end
                OFF_RG:       if (wb_sel_i[0]) rg_d = wb_dat_i[3:0];
                OFF_SEG: begin
                    for (int b = 0; b < 4; b++) begin
                        if (wb_sel_i[b]) seg_d[b*8 +: 8] = wb_dat_i[b*8 +: 8];
                    end
                end
                OFF_INT_EN:   if (wb_sel_i[0]) int_en_d = wb_dat_i[1:0];
                OFF_INT_STAT: if (wb_sel_i[0]) int_clr = wb_dat_i[1:0];
                default: ;
            endcase
        end

        // Edge detection is held off until the history holds a real synced
        // sample, so power-up input levels never raise an interrupt.
        int_set           = 2'b00;
        int_set[INT_SW]   = hist_vld_q & (sw_s != sw_hist_q);
        int_set[INT_STEP] = hist_vld_q & (|(step_s & ~step_hist_q));
        // A new event wins over a simultaneous write-one-to-clear.
        int_stat_d = (int_stat_q & ~int_clr) | int_set;
        irq_d      = |(int_stat_q & int_en_q);

        case (off)
            OFF_LED:      rdata = {16'h0000, led_q};
            OFF_RG:       rdata = {28'h0000000, rg_q};
            OFF_SEG:      rdata = seg_q;
            OFF_SW:       rdata = {24'h000000, sw_s};
            OFF_KEY:      rdata = {22'h000000, step_s, row_s, col_s};
            OFF_INT_EN:   rdata = {30'h00000000, int_en_q};
            OFF_INT_STAT: rdata = {30'h00000000, int_stat_q};
            default:      rdata = 32'h0000_0000;
        endcase
        dat_d = rd_cap ? rdata : 32'h0000_0000;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_q      <= '0;
            sync_vld_q  <= '0;
            sw_hist_q   <= 8'h00;
            step_hist_q <= 2'b00;
            hist_vld_q  <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= 32'h0000_0000;
            led_q       <= LED_RST;
            rg_q        <= RG_RST;
            seg_q       <= SEG_RST;
            int_en_q    <= INT_EN_RST;
            int_stat_q  <= INT_STAT_RST;
            irq_q       <= 1'b0;
        end else begin
            sync_q[0]     <= {btn_step, btn_key_row, btn_key_col, switch};
            sync_vld_q[0] <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i]     <= sync_q[i-1];
                sync_vld_q[i] <= sync_vld_q[i-1];
            end
            sw_hist_q   <= sw_s;
            step_hist_q <= step_s;
            hist_vld_q  <= sync_vld_q[SYNC_STAGES-1];
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            led_q       <= led_d;
            rg_q        <= rg_d;
            seg_q       <= seg_d;
            int_en_q    <= int_en_d;
            int_stat_q  <= int_stat_d;
            irq_q       <= irq_d;
        end
    end

    wb_gpio_panel_seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .seg_i     (seg_q),
        .num_csn_o (num_csn),
        .num_a_g_o (num_a_g)
    );

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign led      = led_q;
    assign led_rg0  = rg_q[1:0];
    assign led_rg1  = rg_q[3:2];
    assign gpio_int = irq_q;

endmodule

// File: tb/tb_wb_gpio_panel.sv
// ---------------------------------------------------------------------------
// tb_wb_gpio_panel
// Directed bench for wb_gpio_panel (SCAN_DIV = 4). Inputs are driven and
// outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_wb_gpio_panel;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic [15:0] led;
    logic [1:0]  led_rg0, led_rg1;
    logic [7:0]  num_csn;
    logic [6:0]  num_a_g;
    logic [7:0]  sw;
    logic [3:0]  key_col, key_row;
    logic [1:0]  step;
    logic        gpio_int;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_gpio_panel #(
        .SCAN_DIV    (4),
        .SYNC_STAGES (2)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wb_cyc_i    (cyc),
        .wb_stb_i    (stb),
        .wb_we_i     (we),
        .wb_adr_i    (adr),
        .wb_sel_i    (sel),
        .wb_dat_i    (dat_w),
        .wb_dat_o    (dat_r),
        .wb_ack_o    (ack),
        .led         (led),
        .led_rg0     (led_rg0),
        .led_rg1     (led_rg1),
        .num_csn     (num_csn),
        .num_a_g     (num_a_g),
        .switch      (sw),
        .btn_key_col (key_col),
        .btn_key_row (key_row),
        .btn_step    (step),
        .gpio_int    (gpio_int)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on a falling edge with the bus idle.
    task automatic wb_xfer(input logic w, input logic [2:0] o, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
        cyc = 1'b1; stb = 1'b1; we = w;
        adr = {27'd0, o, 2'b00}; dat_w = d; sel = s;
        @(negedge clk);
        check("ack_latency", ack, 1'b1);
        rd = dat_r;
        @(negedge clk);
        check("ack_width", ack, 1'b0);
        check("dat_idle", dat_r, 32'h0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wait_csn(input logic [7:0] want, input int limit, input string tag);
        int n = 0;
        while (num_csn !== want && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, num_csn, want);
    endtask

    initial begin
        logic [31:0] rd;
        logic        ack_seen;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 32'h0; sel = 4'h0; dat_w = 32'h0;
        sw = 8'h00; key_col = 4'h0; key_row = 4'h0; step = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_led", led, 16'h0);
        check("rst_csn", num_csn, 8'hFE);
        check("rst_a_g", num_a_g, 7'b0000001);
        check("rst_gpio", gpio_int, 1'b0);
        check("rst_rg", {led_rg1, led_rg0}, 4'h0);
        ack_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ack_seen = ack_seen | ack;
        end
        check("idle_ack", ack_seen, 1'b0);
        check("idle_gpio", gpio_int, 1'b0);

        // LED with byte lane 0 only
        wb_xfer(1'b1, 3'd0, 32'h0000_0000, 4'hF, rd);
        wb_xfer(1'b1, 3'd0, 32'h0000_A5A5, 4'b0001, rd);
        check("led_lane0", led, 16'h00A5);
        wb_xfer(1'b0, 3'd0, 32'h0, 4'hF, rd);
        check("led_read", rd, 32'h0000_00A5);

        // Bicolour LEDs and unused-bit readback
        wb_xfer(1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF, rd);
        check("rg_all", {led_rg1, led_rg0}, 4'hF);
        wb_xfer(1'b0, 3'd1, 32'h0, 4'hF, rd);
        check("rg_read", rd, 32'h0000_000F);
        wb_xfer(1'b1, 3'd1, 32'h0000_0006, 4'b0001, rd);
        check("rg0", led_rg0, 2'b10);
        check("rg1", led_rg1, 2'b01);

        // Display scan
        wb_xfer(1'b1, 3'd2, 32'h8765_4321, 4'hF, rd);
        wait_csn(8'hFE, 40, "scan_first_fe");
        wait_csn(8'h7F, 40, "scan_digit7");
        check("seg_digit7", num_a_g, 7'b0000000);
        wait_csn(8'hFE, 8, "scan_wrap");
        check("seg_digit0", num_a_g, 7'b1001111);
        repeat (3) @(negedge clk);
        check("scan_hold", num_csn, 8'hFE);
        @(negedge clk);
        check("scan_d1", num_csn, 8'hFD);
        check("seg_digit1", num_a_g, 7'b0010010);
        repeat (4) @(negedge clk);
        check("scan_d2", num_csn, 8'hFB);
        check("seg_digit2", num_a_g, 7'b0000110);

        // Switch change interrupt
        wb_xfer(1'b1, 3'd5, 32'h0000_0001, 4'b0001, rd);
        sw = 8'h08;
        repeat (3) @(negedge clk);
        check("sw_gpio_lag", gpio_int, 1'b0);
        @(negedge clk);
        check("sw_gpio_set", gpio_int, 1'b1);
        wb_xfer(1'b0, 3'd3, 32'h0, 4'hF, rd);
        check("sw_read", rd, 32'h0000_0008);
        wb_xfer(1'b0, 3'd6, 32'h0, 4'hF, rd);
        check("stat_sw", rd, 32'h0000_0001);
        wb_xfer(1'b1, 3'd6, 32'h0000_0001, 4'b0001, rd);
        check("w1c_gpio_hold", gpio_int, 1'b1);
        @(negedge clk);
        check("w1c_gpio_fall", gpio_int, 1'b0);
        wb_xfer(1'b0, 3'd6, 32'h0, 4'hF, rd);
        check("stat_cleared", rd, 32'h0);

        // Key matrix readback
        key_col = 4'h9; key_row = 4'h6;
        repeat (3) @(negedge clk);
        wb_xfer(1'b0, 3'd4, 32'h0, 4'hF, rd);
        check("key_read", rd, 32'h0000_0069);

        // Step button with interrupt disabled
        wb_xfer(1'b1, 3'd5, 32'h0, 4'b0001, rd);
        step = 2'b10;
        repeat (3) @(negedge clk);
        wb_xfer(1'b0, 3'd4, 32'h0, 4'hF, rd);
        check("key_step", rd, 32'h0000_0269);
        step = 2'b00;
        repeat (3) @(negedge clk);
        check("step_gpio_masked", gpio_int, 1'b0);
        wb_xfer(1'b0, 3'd6, 32'h0, 4'hF, rd);
        check("stat_step", rd, 32'h0000_0002);
        wb_xfer(1'b1, 3'd6, 32'h0000_0002, 4'b0001, rd);
        wb_xfer(1'b0, 3'd6, 32'h0, 4'hF, rd);
        check("stat_step_clr", rd, 32'h0);

        // New press lands in the same cycle as the clear
        step = 2'b10;
        @(negedge clk);
        wb_xfer(1'b1, 3'd6, 32'h0000_0002, 4'b0001, rd);
        wb_xfer(1'b0, 3'd6, 32'h0, 4'hF, rd);
        check("set_beats_clr", rd, 32'h0000_0002);
        step = 2'b00;
        check("step_gpio_off", gpio_int, 1'b0);

        // Reserved offset
        wb_xfer(1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF, rd);
        wb_xfer(1'b0, 3'd7, 32'h0, 4'hF, rd);
        check("rsvd_read", rd, 32'h0);
        wb_xfer(1'b0, 3'd0, 32'h0, 4'hF, rd);
        check("rsvd_led", rd, 32'h0000_00A5);
        wb_xfer(1'b0, 3'd2, 32'h0, 4'hF, rd);
        check("rsvd_seg", rd, 32'h8765_4321);
        wb_xfer(1'b0, 3'd5, 32'h0, 4'hF, rd);
        check("rsvd_inten", rd, 32'h0);

        // Held strobe: ack every other cycle
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {27'd0, 3'd7, 2'b00}; sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("hold_ack%0d", i), ack, (i % 2 == 1) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_gpio_panel.md
Name: wb_gpio_panel

Overview:
- Wishbone classic slave that gives the CPU data master register access to the board panel.
- Outputs: 16 LEDs, two bicolour LEDs, an 8-digit multiplexed seven-segment display.
- Inputs: 8 switches, 4x4 key matrix lines, 2 step buttons.
- Sits on interconnect slave port 3 and produces the gpio_int line that feeds the CPU int_i vector, bit 2.

Parameters:
- SCAN_DIV, 5000: clock cycles each seven-segment digit stays selected (1 ms at 5 MHz).
- SYNC_STAGES, 2: flip-flop stages on every panel input.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset, synchronous, active-high
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  write enable
- wb_adr_i  in  32  byte address; only [4:2] is decoded
- wb_sel_i  in  4  byte lane enables
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  acknowledge
- led  out  16  LED drive, 1 = on
- led_rg0  out  2  bicolour LED 0 {green, red}
- led_rg1  out  2  bicolour LED 1 {green, red}
- num_csn  out  8  digit select, active-low one-hot
- num_a_g  out  7  segments [6]=a .. [0]=g, active-low
- switch  in  8  raw switches
- btn_key_col  in  4  raw key columns
- btn_key_row  in  4  raw key rows
- btn_step  in  2  raw step buttons, 1 = pressed
- gpio_int  out  1  level interrupt, active-high

Behaviour:
- Clocking and reset: one clock, wb_clk_i. All state is reset synchronously while wb_rst_i = 1.
- Register map (word offset = adr[4:2]):
  - 0 LED: RW, [15:0]
  - 1 RG: RW, [3:2] = led_rg1, [1:0] = led_rg0
  - 2 SEG: RW, [31:0]; nibble n drives digit n
  - 3 SW: RO, [7:0] synced switch
  - 4 KEY: RO, [9:8] synced btn_step, [7:4] row, [3:0] col
  - 5 INT_EN: RW, [1:0]
  - 6 INT_STAT: W1C, [1:0]
  - 7: reserved; reads 0, writes ignored
  - Unused bits read 0.
- Handshake:
  - wb_ack_o is registered: ack <= cyc & stb & ~ack.
  - Each access acks exactly one cycle after the request is seen. Ack then drops for one cycle, so a held stb gives ack every other cycle.
  - Writes commit in the ack cycle, per byte lane selected by wb_sel_i.
  - wb_dat_o is registered and valid in the ack cycle; it is 0 at all other times.
  - Reserved offsets still ack.
  - No err/rty generated.
- Input sync: every panel input passes SYNC_STAGES flops before use. Raw inputs are never read directly.
- Interrupt sources:
  - INT_STAT[0] sets on any cycle where synced switch differs from its value one cycle earlier.
  - INT_STAT[1] sets on a rising edge of either synced btn_step bit.
  - Set takes priority over a W1C clear in the same cycle.
  - gpio_int is registered: gpio_int <= |(INT_STAT & INT_EN).
- Display scan:
  - A counter runs 0..SCAN_DIV-1. At wrap, digit index 0..7 increments, and wraps 7 -> 0.
  - num_csn = ~(1 << index). num_a_g = active-low hex decode of SEG nibble[index], glyphs 0-9 and A-F.
  - The outputs are registered, so a SEG write is visible on the next digit refresh, with no glitch mid-digit.
- Reset values:
  - LED, RG, SEG, INT_EN, INT_STAT, counters, index and edge history = 0.
  - wb_ack_o, wb_dat_o, gpio_int = 0.
  - led = 0, led_rg0 = led_rg1 = 0.
  - num_csn = 8'hFE; num_a_g = decode of 0 = 7'b0000001.
  - Edge-history flops load the first synced value without setting INT_STAT.
- Reset mid-transaction: ack drops the next cycle and no write commits. The master must reissue the access.

Decomposition:
- Shared package/defines: register offsets, INT bit indices, the hex-to-segment constant table, and a reset value for each register.
- One natural sub-module: seg_scan (scan counter, digit index, decode, registered outputs).
- Bus decode, registers and interrupt logic stay in the top.

Test Plan:
- Reset, then idle 10 cycles -> led = 0, num_csn = FE, num_a_g = 7'b0000001, gpio_int = 0, ack never asserted.
- Write LED = 32'h0000_A5A5 with sel = 4'b0001 after a prior full write of 0 -> led = 16'h00A5. Ack follows stb by one cycle and is one cycle wide. Readback = 0000_00A5.
- SEG = 32'h8765_4321, SCAN_DIV = 4 -> num_csn steps FE, FD, FB, ... every 4 cycles. Digit 0 shows "1" (7'b1001111). Index wraps to FE after digit 7.
- INT_EN = 2'b01, then toggle switch[3] -> INT_STAT[0] = 1 after the sync delay, and gpio_int = 1 one cycle later. Write INT_STAT = 1 -> gpio_int falls the cycle after the write.
- Pulse btn_step[1] with INT_EN = 0 -> INT_STAT = 2'b10 and gpio_int stays 0. W1C in the same cycle as a new press -> bit stays 1.
- Read offset 7 and write offset 7 -> both ack, read data = 0, no register changes. Hold stb for 6 cycles -> ack pattern 0,1,0,1,0,1.
